// File: rtl/lrf_pkg.sv
// rtl/lrf_pkg.sv - shared modes, widths and lane slicing for the LRF similarity datapath
`ifndef LRF_LANE
`define LRF_LANE(vec, i, w) vec[(i)*(w) +: (w)]
`endif

package lrf_pkg;
  localparam logic [1:0] MODE_XY = 2'd0;
  localparam logic [1:0] MODE_XX = 2'd1;
  localparam logic [1:0] MODE_YY = 2'd2;

  function automatic int gw_width(input int pix_w, input int mu_frac);
    return 2 * (pix_w + mu_frac);
  endfunction

  function automatic int out_width(input int pix_w, input int mu_frac);
    return gw_width(pix_w, mu_frac) + 1;
  endfunction

  // The reserved encoding behaves as the cross term.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_XY : m;
  endfunction
endpackage

// File: rtl/conv_gauss.sv
// rtl/conv_gauss.sv - vertical [1 2 1]/4 Gaussian window over lines; output valid once two lines are buffered
module conv_gauss
  import lrf_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int DW        = 24,
  parameter int IMAGE_DIM = 512,
  parameter int USER_W    = 2
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  stall,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [USER_W-1:0]     in_user,
  output logic                  g_valid,
  output logic [LANES*DW-1:0]   g_data,
  output logic [USER_W-1:0]     g_user
);
  localparam int BEATS = IMAGE_DIM / LANES;
  localparam int PW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = $clog2(2 * BEATS + 1);

  logic [LANES*DW-1:0] lb0 [BEATS];
  logic [LANES*DW-1:0] lb1 [BEATS];
  logic [LANES*DW-1:0] window;
  logic [PW-1:0]       ptr, cur_ptr, nxt_ptr;
  logic [CW-1:0]       cnt, cur_cnt;
  logic                filled;

  always_comb begin
    cur_ptr = in_sof ? '0 : ptr;
    cur_cnt = in_sof ? '0 : cnt;
    filled  = (cur_cnt == CW'(2 * BEATS));
    nxt_ptr = (cur_ptr == PW'(BEATS - 1)) ? '0 : cur_ptr + PW'(1);
  end

  // lb1 holds the previous line, lb0 the one before it, both read before this beat overwrites them.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW+1:0] acc;
    assign acc = {2'b00, `LRF_LANE(lb0[cur_ptr], i, DW)}
               + {1'b0, `LRF_LANE(lb1[cur_ptr], i, DW), 1'b0}
               + {2'b00, `LRF_LANE(in_data, i, DW)};
    assign `LRF_LANE(window, i, DW) = DW'(acc >> 2);
  end

  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      lb0[cur_ptr] <= lb1[cur_ptr];
      lb1[cur_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      ptr     <= '0;
      cnt     <= '0;
      g_valid <= 1'b0;
      g_data  <= '0;
      g_user  <= '0;
    end else if (!stall) begin
      g_valid <= in_valid && filled;
      g_data  <= window;
      g_user  <= in_user;
      if (in_valid) begin
        ptr <= nxt_ptr;
        if (!filled) cnt <= cur_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sig_cov_mu_fifo.sv
// rtl/sig_cov_mu_fifo.sv - in-order mean-pair FIFO with stall-gated push/pop and error pulses
module sig_cov_mu_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         stall,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty,
  output logic         ovf,
  output logic         udf
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         full, do_push, do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop   = pop && !empty && !stall;
  // A pop in the same cycle frees the slot, so push+pop while full is accepted.
  assign do_push  = push && !stall && (!full || do_pop);
  assign ovf      = push && !stall && full && !do_pop;
  assign udf      = pop && !stall && empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: rtl/sig_cov.sv
// rtl/sig_cov.sv - multi-lane local (co)variance: sigma = G*(a*b) - mu_a*mu_b, mode-selectable XY/XX/YY
module sig_cov
  import lrf_pkg::*;
#(
  parameter int LANES     = 16,
  parameter int PIX_W     = 8,
  parameter int MU_FRAC   = 4,
  parameter int IMAGE_DIM = 512,
  parameter int MU_DEPTH  = 8,
  parameter int CLAMP_VAR = 1
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic                                        stall,
  input  logic                                        sof,
  input  logic [1:0]                                  mode,
  input  logic                                        in_valid,
  input  logic [LANES*PIX_W-1:0]                      in_x,
  input  logic [LANES*PIX_W-1:0]                      in_y,
  input  logic                                        mu_valid,
  input  logic [LANES*(PIX_W+MU_FRAC)-1:0]            mu_a,
  input  logic [LANES*(PIX_W+MU_FRAC)-1:0]            mu_b,
  output logic                                        out_valid,
  output logic [LANES*out_width(PIX_W, MU_FRAC)-1:0]  out,
  output logic [1:0]                                  err
);
  localparam int MU_W  = PIX_W + MU_FRAC;
  localparam int GW    = gw_width(PIX_W, MU_FRAC);
  localparam int OUT_W = out_width(PIX_W, MU_FRAC);

  logic [1:0]             mode_q, in_mode;
  logic                   s1_valid, s1_sof;
  logic [1:0]             s1_mode;
  logic [LANES*PIX_W-1:0] s1_a, s1_b;
  logic                   s2_valid, s2_sof;
  logic [1:0]             s2_mode;
  logic [LANES*GW-1:0]    s2_p, p_next;
  logic                   g_valid;
  logic [LANES*GW-1:0]    g_data;
  logic [1:0]             g_mode;
  logic [2*LANES*MU_W-1:0] fifo_head;
  logic                   fifo_empty, ovf, udf;
  logic                   s3_valid;
  logic [1:0]             s3_mode;
  logic [LANES*GW-1:0]    s3_g, s3_m, m_next;
  logic [LANES*OUT_W-1:0] d_next;

  // The sof beat itself already runs in the newly requested mode.
  assign in_mode = (sof && in_valid) ? norm_mode(mode) : mode_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    (* use_dsp = "yes" *) logic [2*PIX_W-1:0] p;
    (* use_dsp = "yes" *) logic [GW-1:0]      m;
    logic [OUT_W-1:0] d;
    assign p = {{PIX_W{1'b0}}, `LRF_LANE(s1_a, i, PIX_W)} * {{PIX_W{1'b0}}, `LRF_LANE(s1_b, i, PIX_W)};
    assign `LRF_LANE(p_next, i, GW) = {p, {(2*MU_FRAC){1'b0}}};
    assign m = {{MU_W{1'b0}}, `LRF_LANE(fifo_head, LANES + i, MU_W)}
             * {{MU_W{1'b0}}, `LRF_LANE(fifo_head, i, MU_W)};
    assign `LRF_LANE(m_next, i, GW) = m;
    assign d = {1'b0, `LRF_LANE(s3_g, i, GW)} - {1'b0, `LRF_LANE(s3_m, i, GW)};
    assign `LRF_LANE(d_next, i, OUT_W) =
      (CLAMP_VAR != 0 && s3_mode != MODE_XY && d[OUT_W-1]) ? '0 : d;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      mode_q   <= MODE_XY;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_mode  <= MODE_XY;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_sof   <= 1'b0;
      s2_mode  <= MODE_XY;
      s2_p     <= '0;
    end else if (!stall) begin
      if (sof && in_valid) mode_q <= norm_mode(mode);
      s1_valid <= in_valid;
      s1_sof   <= sof && in_valid;
      s1_mode  <= in_mode;
      s1_a     <= (in_mode == MODE_YY) ? in_y : in_x;
      s1_b     <= (in_mode == MODE_XX) ? in_x : in_y;
      s2_valid <= s1_valid;
      s2_sof   <= s1_sof;
      s2_mode  <= s1_mode;
      s2_p     <= p_next;
    end
  end

  conv_gauss #(
    .LANES(LANES), .DW(GW), .IMAGE_DIM(IMAGE_DIM), .USER_W(2)
  ) u_conv_gauss (
    .clk(clk), .aresetn(aresetn), .stall(stall),
    .in_valid(s2_valid), .in_sof(s2_sof), .in_data(s2_p), .in_user(s2_mode),
    .g_valid(g_valid), .g_data(g_data), .g_user(g_mode)
  );

  sig_cov_mu_fifo #(
    .W(2 * LANES * MU_W), .DEPTH(MU_DEPTH)
  ) u_mu_fifo (
    .clk(clk), .aresetn(aresetn), .stall(stall),
    .push(mu_valid), .push_data({mu_a, mu_b}),
    .pop(g_valid), .pop_data(fifo_head),
    .empty(fifo_empty), .ovf(ovf), .udf(udf)
  );

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s3_valid  <= 1'b0;
      s3_mode   <= MODE_XY;
      s3_g      <= '0;
      s3_m      <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      err       <= 2'b00;
    end else if (!stall) begin
      s3_valid  <= g_valid && !fifo_empty;
      s3_mode   <= g_mode;
      s3_g      <= g_data;
      s3_m      <= m_next;
      out_valid <= s3_valid;
      if (s3_valid) out <= d_next;
      err       <= err | {udf, ovf};
    end
  end
endmodule

// File: tb/tb_sig_cov.sv
// tb/tb_sig_cov.sv - self-checking bench for sig_cov against a line-window reference model
module tb_sig_cov;
  localparam int L = 4, PW = 8, MF = 4, DIM = 16, DEPTH = 8, CLAMP = 1;
  localparam int MW = PW + MF, OW = 2 * MW + 1, B = DIM / L, MAXB = 64;
  typedef logic [L*OW-1:0] beat_t;
  typedef logic [L*MW-1:0] mu_t;

  logic clk = 1'b0, aresetn = 1'b0, stall = 1'b0, sof = 1'b0, in_valid = 1'b0, mu_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [L*PW-1:0] in_x = '0, in_y = '0;
  mu_t mu_a = '0, mu_b = '0;
  logic out_valid;
  beat_t out;
  logic [1:0] err;

  int checks = 0, errors = 0;
  int fx [MAXB][L];
  int fy [MAXB][L];
  mu_t mua_tab [MAXB];
  mu_t mub_tab [MAXB];
  mu_t mq_a [$];
  mu_t mq_b [$];
  beat_t got [$];
  beat_t exp_q [$];
  logic col_st, col_rs;

  sig_cov #(
    .LANES(L), .PIX_W(PW), .MU_FRAC(MF), .IMAGE_DIM(DIM), .MU_DEPTH(DEPTH), .CLAMP_VAR(CLAMP)
  ) dut (
    .clk(clk), .aresetn(aresetn), .stall(stall), .sof(sof), .mode(mode),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .mu_valid(mu_valid), .mu_a(mu_a), .mu_b(mu_b),
    .out_valid(out_valid), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  // Capture one result per non-stalled edge that produced a valid beat.
  always @(posedge clk) begin
    col_st = stall;
    col_rs = aresetn;
    #1;
    if (col_rs && !col_st && out_valid) got.push_back(out);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void fill_pix(input int x, input int y);
    for (int k = 0; k < MAXB; k++)
      for (int l = 0; l < L; l++) begin fx[k][l] = x; fy[k][l] = y; end
  endfunction

  function automatic void fill_mu(input int ma, input int mb);
    for (int k = 0; k < MAXB; k++)
      for (int l = 0; l < L; l++) begin
        mua_tab[k][l*MW +: MW] = MW'(ma);
        mub_tab[k][l*MW +: MW] = MW'(mb);
      end
  endfunction

  function automatic void fill_rand();
    for (int k = 0; k < MAXB; k++) begin
      for (int l = 0; l < L; l++) begin
        fx[k][l] = int'($urandom_range(0, 255));
        fy[k][l] = int'($urandom_range(0, 255));
      end
      mua_tab[k] = mu_t'({$urandom, $urandom});
      mub_tab[k] = mu_t'({$urandom, $urandom});
    end
  endfunction

  // Scaled product of one lane of one beat, as the selected SSIM term defines it.
  function automatic longint prod(input int k, input int l, input int md);
    longint a, b;
    a = (md == 2) ? fy[k][l] : fx[k][l];
    b = (md == 1) ? fx[k][l] : fy[k][l];
    return a * b * 256;
  endfunction

  // Gaussian over rows r-2, r-1, r for every beat once two full lines have arrived; paired in order with means.
  task automatic model_frame(input int md_in, input int nb);
    int md;
    md = (md_in == 3) ? 0 : md_in;
    for (int k = 2 * B; k < nb; k++) begin
      mu_t ma, mb;
      beat_t e;
      if (mq_a.size() == 0) continue;
      ma = mq_a.pop_front();
      mb = mq_b.pop_front();
      e = '0;
      for (int l = 0; l < L; l++) begin
        longint g, m, av, bv, d;
        g  = (prod(k - 2 * B, l, md) + 2 * prod(k - B, l, md) + prod(k, l, md)) / 4;
        av = longint'({52'd0, ma[l*MW +: MW]});
        bv = longint'({52'd0, mb[l*MW +: MW]});
        m  = av * bv;
        d  = g - m;
        if (CLAMP != 0 && md != 0 && d < 0) d = 0;
        e[l*OW +: OW] = d[OW-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, "_count"}, 128'(got.size()), 128'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check(tag, 128'(got[i]), 128'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  task automatic accept(input int pct);
    bit s;
    do begin
      s = (pct > 0) && (int'($urandom_range(0, 99)) < pct);
      stall = s;
      @(negedge clk);
    end while (s);
    stall = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0; sof = 1'b0; mu_valid = 1'b0; stall = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input int md, input int nb, input bit use_mu, input int pct);
    for (int k = 0; k < nb; k++) begin
      in_valid = 1'b1;
      sof      = (k == 0);
      mode     = (k == 0) ? 2'(md) : 2'($urandom_range(0, 3));
      for (int l = 0; l < L; l++) begin
        in_x[l*PW +: PW] = PW'(fx[k][l]);
        in_y[l*PW +: PW] = PW'(fy[k][l]);
      end
      if (use_mu && k >= 2 * B) begin
        mu_valid = 1'b1;
        mu_a = mua_tab[k - 2 * B];
        mu_b = mub_tab[k - 2 * B];
        mq_a.push_back(mu_a);
        mq_b.push_back(mu_b);
      end else begin
        mu_valid = 1'b0;
      end
      accept(pct);
    end
    in_valid = 1'b0; sof = 1'b0; mu_valid = 1'b0;
  endtask

  task automatic reset_dut();
    aresetn = 1'b0;
    idle(2);
    aresetn = 1'b1;
    got.delete(); exp_q.delete(); mq_a.delete(); mq_b.delete();
  endtask

  initial begin
    int md;
    reset_dut();
    idle(3);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_out", 128'(out), 128'(0));

    fill_pix(200, 100); fill_mu(3200, 1600);
    run_frame(0, 24, 1, 0); idle(8); model_frame(0, 24);
    for (int i = 0; i < exp_q.size(); i++) check("flat_xy_zero", 128'(exp_q[i]), 128'(0));
    check_frame("flat_xy");
    check("flat_err", 128'(err), 128'(0));

    for (int k = 0; k < MAXB; k++)
      for (int l = 0; l < L; l++) begin
        fx[k][l] = ((l + k / B) % 2 == 1) ? 255 : 0;
        fy[k][l] = fx[k][l];
      end
    fill_mu(2040, 2040);
    run_frame(1, 24, 1, 0); idle(8); model_frame(1, 24); check_frame("checker_xx");

    fill_pix(100, 100); fill_mu(1601, 1601);
    run_frame(1, 20, 1, 0); idle(8); model_frame(1, 20); check_frame("clamp_xx");
    run_frame(0, 20, 1, 0); idle(8); model_frame(0, 20); check_frame("noclamp_xy");

    fill_rand();
    run_frame(0, 24, 1, 0); idle(8); model_frame(0, 24); check_frame("switch_xy");
    run_frame(2, 24, 1, 0); idle(8); model_frame(2, 24); check_frame("switch_yy");

    fill_rand();
    md = int'($urandom_range(0, 3));
    run_frame(md, 48, 1, 0);  idle(8); model_frame(md, 48); check_frame("rand_nostall");
    run_frame(md, 48, 1, 30); idle(8); model_frame(md, 48); check_frame("rand_stall");
    run_frame(3, 32, 1, 30);  idle(8); model_frame(3, 32); check_frame("rsvd_stall");
    check("rand_err", 128'(err), 128'(0));

    fill_rand();
    run_frame(0, 10, 1, 0);
    reset_dut();
    idle(10);
    check("midrst_no_out", 128'(got.size()), 128'(0));
    check("midrst_err", 128'(err), 128'(0));
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    run_frame(0, 12, 0, 0); idle(8);
    check("udf_err", 128'(err), 128'(2'b10));
    check("udf_no_out", 128'(got.size()), 128'(0));

    reset_dut();
    fill_rand();
    for (int j = 0; j < DEPTH + 1; j++) begin
      mu_valid = 1'b1;
      mu_a = mua_tab[j];
      mu_b = mub_tab[j];
      if (j < DEPTH) begin mq_a.push_back(mu_a); mq_b.push_back(mu_b); end
      accept(0);
    end
    idle(2);
    check("ovf_err", 128'(err), 128'(2'b01));
    run_frame(0, 20, 0, 0); idle(8); model_frame(0, 20); check_frame("ovf_pairs");
    check("ovf_udf_err", 128'(err), 128'(2'b11));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
